// File: rtl/vpu_dma_sram_arbiter.sv
// Two-port (VPU / DMA) arbiter onto four XOR-interleaved SRAM banks with round-robin conflict resolution.
// Optional contested-cycle counter is enabled by defining ARB_PERF_CNT_EN.
module vpu_dma_sram_arbiter #(
  parameter int SRAM_WIDTH = 256,
  parameter int WORD_W     = 8,
  parameter int ADDR_W     = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_req_valid,
  output logic                    a_req_ready,
  input  logic                    a_req_we,
  input  logic [ADDR_W-1:0]       a_req_addr,
  input  logic [SRAM_WIDTH-1:0]   a_req_wdata,
  output logic                    a_rsp_valid,
  output logic [SRAM_WIDTH-1:0]   a_rsp_data,
  input  logic                    b_req_valid,
  output logic                    b_req_ready,
  input  logic                    b_req_we,
  input  logic [ADDR_W-1:0]       b_req_addr,
  input  logic [SRAM_WIDTH-1:0]   b_req_wdata,
  output logic                    b_rsp_valid,
  output logic [SRAM_WIDTH-1:0]   b_rsp_data,
  output logic [3:0]              bank_en,
  output logic [3:0]              bank_we,
  output logic [4*WORD_W-1:0]     bank_addr,
  output logic [4*SRAM_WIDTH-1:0] bank_wdata,
  input  logic [4*SRAM_WIDTH-1:0] bank_rdata,
  output logic [31:0]             conflict_count
);

  logic [1:0]        bank_a, bank_b;
  logic [WORD_W-1:0] word_a, word_b;
  logic              contested;
  logic              a_grant, b_grant;
  logic              prio_q;              // 0 = A wins next contest, 1 = B
  logic              a_rsp_v_q, b_rsp_v_q;
  logic [1:0]        a_rsp_bank_q, b_rsp_bank_q;
  logic              unused_addr_bits;

  assign bank_a = a_req_addr[1:0] ^ a_req_addr[9:8];
  assign bank_b = b_req_addr[1:0] ^ b_req_addr[9:8];
  assign word_a = a_req_addr[WORD_W+1:2];
  assign word_b = b_req_addr[WORD_W+1:2];
  assign unused_addr_bits = ^{a_req_addr[ADDR_W-1:10], b_req_addr[ADDR_W-1:10]};

  assign contested   = a_req_valid & b_req_valid & (bank_a == bank_b);
  assign a_req_ready = ~rst & ~(contested & prio_q);
  assign b_req_ready = ~rst & ~(contested & ~prio_q);
  assign a_grant     = a_req_valid & a_req_ready;
  assign b_grant     = b_req_valid & b_req_ready;

  // Grants never overlap on a bank, so a simple priority mux per bank suffices.
  always_comb begin
    bank_en    = '0;
    bank_we    = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    for (int k = 0; k < 4; k++) begin
      if (a_grant && bank_a == 2'(k)) begin
        bank_en[k] = 1'b1;
        bank_we[k] = a_req_we;
        bank_addr[k*WORD_W +: WORD_W]          = word_a;
        bank_wdata[k*SRAM_WIDTH +: SRAM_WIDTH] = a_req_wdata;
      end else if (b_grant && bank_b == 2'(k)) begin
        bank_en[k] = 1'b1;
        bank_we[k] = b_req_we;
        bank_addr[k*WORD_W +: WORD_W]          = word_b;
        bank_wdata[k*SRAM_WIDTH +: SRAM_WIDTH] = b_req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q       <= 1'b0;
      a_rsp_v_q    <= 1'b0;
      b_rsp_v_q    <= 1'b0;
      a_rsp_bank_q <= 2'd0;
      b_rsp_bank_q <= 2'd0;
    end else begin
      if (contested) prio_q <= ~prio_q;
      a_rsp_v_q    <= a_grant & ~a_req_we;
      b_rsp_v_q    <= b_grant & ~b_req_we;
      a_rsp_bank_q <= bank_a;
      b_rsp_bank_q <= bank_b;
    end
  end

  // Gated by rst so a read granted just before reset never returns.
  assign a_rsp_valid = a_rsp_v_q & ~rst;
  assign b_rsp_valid = b_rsp_v_q & ~rst;
  assign a_rsp_data  = a_rsp_valid ? bank_rdata[a_rsp_bank_q*SRAM_WIDTH +: SRAM_WIDTH] : '0;
  assign b_rsp_data  = b_rsp_valid ? bank_rdata[b_rsp_bank_q*SRAM_WIDTH +: SRAM_WIDTH] : '0;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= '0;
    end else if (contested && conflict_q != 32'hFFFF_FFFF) begin
      conflict_q <= conflict_q + 32'd1;
    end
  end

  assign conflict_count = conflict_q;
`else
  assign conflict_count = '0;
`endif

endmodule

// File: tb/tb_vpu_dma_sram_arbiter.sv
// Directed-vector bench for vpu_dma_sram_arbiter with a behavioural 4-bank SRAM read model.
module tb_vpu_dma_sram_arbiter;
  localparam int SW = 256;
`ifdef ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           a_req_valid, a_req_ready, a_req_we;
  logic [19:0]    a_req_addr;
  logic [SW-1:0]  a_req_wdata;
  logic           a_rsp_valid;
  logic [SW-1:0]  a_rsp_data;
  logic           b_req_valid, b_req_ready, b_req_we;
  logic [19:0]    b_req_addr;
  logic [SW-1:0]  b_req_wdata;
  logic           b_rsp_valid;
  logic [SW-1:0]  b_rsp_data;
  logic [3:0]     bank_en, bank_we;
  logic [31:0]    bank_addr;
  logic [4*SW-1:0] bank_wdata, bank_rdata;
  logic [31:0]    conflict_count;
  logic [SW-1:0]  rd_q [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vpu_dma_sram_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .conflict_count(conflict_count)
  );

  function automatic logic [SW-1:0] pat(int k, logic [7:0] w);
    logic [7:0] kb;
    kb = 8'hA0 + 8'(k);
    return {16{kb, w}};
  endfunction

  // Synchronous-read SRAM model: data for the word presented with bank_en appears next cycle.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (bank_en[k] && !bank_we[k]) rd_q[k] <= pat(k, bank_addr[k*8 +: 8]);
  end
  assign bank_rdata = {rd_q[3], rd_q[2], rd_q[1], rd_q[0]};

  task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) rd_q[k] = '0;
    rst = 1'b1;
    idle();
    a_req_valid = 1'b1; a_req_addr = 20'h00020;
    b_req_valid = 1'b1; b_req_addr = 20'h00021;
    repeat (3) cyc();
    #1;
    chk("rst_a_ready", SW'(a_req_ready), '0);
    chk("rst_b_ready", SW'(b_req_ready), '0);
    chk("rst_bank_en", SW'(bank_en), '0);
    chk("rst_a_rsp_valid", SW'(a_rsp_valid), '0);
    chk("rst_conflict", SW'(conflict_count), '0);

    cyc(); rst = 1'b0; idle(); #1;
    chk("idle_a_ready", SW'(a_req_ready), SW'(1));
    chk("idle_b_ready", SW'(b_req_ready), SW'(1));
    chk("idle_bank_en", SW'(bank_en), '0);

    // A read 0x020 alone: bank 0, word 8
    cyc(); a_req_valid = 1'b1; a_req_addr = 20'h00020; #1;
    chk("t1_a_ready", SW'(a_req_ready), SW'(1));
    chk("t1_bank_en", SW'(bank_en), SW'(4'b0001));
    chk("t1_bank_we", SW'(bank_we), '0);
    chk("t1_addr0", SW'(bank_addr[7:0]), SW'(8));
    cyc(); idle(); #1;
    chk("t1_a_rsp_valid", SW'(a_rsp_valid), SW'(1));
    chk("t1_a_rsp_data", a_rsp_data, pat(0, 8'd8));
    chk("t1_b_rsp_valid", SW'(b_rsp_valid), '0);
    cyc(); #1;
    chk("t1_a_rsp_drop", SW'(a_rsp_valid), '0);
    chk("t1_a_data_zero", a_rsp_data, '0);

    // Different banks in one cycle: both granted
    cyc(); a_req_valid = 1'b1; a_req_addr = 20'h00020; b_req_valid = 1'b1; b_req_addr = 20'h00021; #1;
    chk("t2_a_ready", SW'(a_req_ready), SW'(1));
    chk("t2_b_ready", SW'(b_req_ready), SW'(1));
    chk("t2_bank_en", SW'(bank_en), SW'(4'b0011));
    chk("t2_addr1", SW'(bank_addr[15:8]), SW'(8));
    cyc(); idle(); #1;
    chk("t2_a_rsp", SW'(a_rsp_valid), SW'(1));
    chk("t2_b_rsp", SW'(b_rsp_valid), SW'(1));
    chk("t2_a_data", a_rsp_data, pat(0, 8'd8));
    chk("t2_b_data", b_rsp_data, pat(1, 8'd8));
    chk("t2_conflict", SW'(conflict_count), '0);

    // Same bank: A wins first, B held and granted next cycle
    cyc(); a_req_valid = 1'b1; a_req_addr = 20'h00020; b_req_valid = 1'b1; b_req_addr = 20'h00024; #1;
    chk("t3_c1_a_ready", SW'(a_req_ready), SW'(1));
    chk("t3_c1_b_ready", SW'(b_req_ready), '0);
    chk("t3_c1_bank_en", SW'(bank_en), SW'(4'b0001));
    chk("t3_c1_addr0", SW'(bank_addr[7:0]), SW'(8));
    cyc(); a_req_valid = 1'b0; #1;
    chk("t3_c2_b_ready", SW'(b_req_ready), SW'(1));
    chk("t3_c2_addr0", SW'(bank_addr[7:0]), SW'(9));
    chk("t3_c2_a_rsp", SW'(a_rsp_valid), SW'(1));
    chk("t3_c2_a_data", a_rsp_data, pat(0, 8'd8));
    cyc(); idle(); #1;
    chk("t3_b_rsp", SW'(b_rsp_valid), SW'(1));
    chk("t3_b_data", b_rsp_data, pat(0, 8'd9));
    chk("t3_a_rsp_drop", SW'(a_rsp_valid), '0);
    chk("t3_conflict", SW'(conflict_count), PERF ? SW'(1) : '0);

    // Upper address bits ignored: 0xF0021 -> bank 1, word 8; pointer is now B but uncontested
    cyc(); a_req_valid = 1'b1; a_req_addr = 20'hF0021; #1;
    chk("hi_bank_en", SW'(bank_en), SW'(4'b0010));
    chk("hi_addr1", SW'(bank_addr[15:8]), SW'(8));
    // Reset arrives the cycle after the grant: response must be suppressed
    cyc(); idle(); rst = 1'b1; #1;
    chk("rr_a_rsp_in_rst", SW'(a_rsp_valid), '0);
    chk("rr_a_data_in_rst", a_rsp_data, '0);
    cyc(); rst = 1'b0; #1;
    chk("rr_a_rsp_after", SW'(a_rsp_valid), '0);
    chk("rr_conflict", SW'(conflict_count), '0);

    // Continuous contested writes to bank 0: A,B,A,B starting from reset pointer
    cyc();
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 20'h00030; a_req_wdata = {8{32'h1111_AAAA}};
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 20'h00034; b_req_wdata = {8{32'h2222_BBBB}};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t4_a_ready_%0d", i), SW'(a_req_ready), SW'(i % 2 == 0));
      chk($sformatf("t4_b_ready_%0d", i), SW'(b_req_ready), SW'(i % 2 == 1));
      chk($sformatf("t4_bank_we_%0d", i), SW'(bank_we), SW'(4'b0001));
      chk($sformatf("t4_addr0_%0d", i), SW'(bank_addr[7:0]), (i % 2 == 0) ? SW'(12) : SW'(13));
      chk($sformatf("t4_wdata0_%0d", i), bank_wdata[SW-1:0], (i % 2 == 0) ? {8{32'h1111_AAAA}} : {8{32'h2222_BBBB}});
      chk($sformatf("t4_rsp_%0d", i), SW'({a_rsp_valid, b_rsp_valid}), '0);
      cyc();
    end
    idle(); #1;
    chk("t4_conflict", SW'(conflict_count), PERF ? SW'(4) : '0);
    chk("t4_rsp_after", SW'({a_rsp_valid, b_rsp_valid}), '0);

    // B write 0x100: bank 1, word 0x40
    cyc(); b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 20'h00100; b_req_wdata = {8{32'hCAFE_0001}}; #1;
    chk("t5_bank_en", SW'(bank_en), SW'(4'b0010));
    chk("t5_bank_we", SW'(bank_we), SW'(4'b0010));
    chk("t5_addr1", SW'(bank_addr[15:8]), SW'(8'h40));
    chk("t5_wdata1", bank_wdata[2*SW-1:SW], {8{32'hCAFE_0001}});
    cyc(); idle(); #1;
    chk("t5_no_b_rsp", SW'(b_rsp_valid), '0);
    chk("t5_b_data_zero", b_rsp_data, '0);

    // Back-to-back reads on B: words 1 and 2 of bank 1 (addr 0x005, 0x009)
    cyc(); b_req_valid = 1'b1; b_req_addr = 20'h00005; #1;
    chk("bb_bank_en0", SW'(bank_en), SW'(4'b0010));
    cyc(); b_req_addr = 20'h00009; #1;
    chk("bb_rsp0", SW'(b_rsp_valid), SW'(1));
    chk("bb_data0", b_rsp_data, pat(1, 8'd1));
    cyc(); idle(); #1;
    chk("bb_rsp1", SW'(b_rsp_valid), SW'(1));
    chk("bb_data1", b_rsp_data, pat(1, 8'd2));
    cyc(); #1;
    chk("bb_rsp_end", SW'(b_rsp_valid), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
